// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the 4x4 matrix keypad scanner.
// Key indices are col*4 + row, so bit n of any 16-bit key map is key n.
package keypad_scanner_pkg;

    localparam int COLS = 4;
    localparam int ROWS = 4;

    // Column drive after reset: column 0 pulled low, others released.
    localparam logic [COLS-1:0] COL_RESET = 4'b1110;

    // Key index constants, named by their position in the scan order.
    localparam logic [3:0] KEY_0 = 4'd0;   // col 0, row 0
    localparam logic [3:0] KEY_1 = 4'd1;   // col 0, row 1
    localparam logic [3:0] KEY_2 = 4'd2;   // col 0, row 2
    localparam logic [3:0] KEY_3 = 4'd3;   // col 0, row 3
    localparam logic [3:0] KEY_4 = 4'd4;   // col 1, row 0
    localparam logic [3:0] KEY_5 = 4'd5;   // col 1, row 1
    localparam logic [3:0] KEY_6 = 4'd6;   // col 1, row 2
    localparam logic [3:0] KEY_7 = 4'd7;   // col 1, row 3
    localparam logic [3:0] KEY_8 = 4'd8;   // col 2, row 0
    localparam logic [3:0] KEY_9 = 4'd9;   // col 2, row 1
    localparam logic [3:0] KEY_A = 4'd10;  // col 2, row 2
    localparam logic [3:0] KEY_B = 4'd11;  // col 2, row 3
    localparam logic [3:0] KEY_C = 4'd12;  // col 3, row 0
    localparam logic [3:0] KEY_D = 4'd13;  // col 3, row 1
    localparam logic [3:0] KEY_E = 4'd14;  // col 3, row 2
    localparam logic [3:0] KEY_F = 4'd15;  // col 3, row 3

    // Index of the lowest set bit of a key map; 0 when the map is empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] keys);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (keys[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_pulse.sv
// scan_pulse: free-running divider for the keypad column scan.
// count runs 0..DIV-1 and wraps; tick is high for the single cycle at DIV-1.
module scan_pulse #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Divider counter, wrapping at DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-matrix snapshots and reports new presses as key events.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat of the held key.
//
// Event interface: key_valid is a one-cycle pulse with no back-pressure;
// key_code is valid in that cycle and holds its value until the next event.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 125,
    parameter int REPEAT_RATE    = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    output logic [3:0]           key_code,
    output logic                 key_valid,
    output logic                 key_down,
    output logic [15:0]          keys_stable
);

    // Elaboration-time parameter sanity. Repeat timings are checked in every
    // build so toggling the repeat feature never changes the legal set.
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_SCANS must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [SW-1:0] CNT_MAX = SW'(DEBOUNCE_SCANS - 1);

    // ------------------------------------------------------------------
    // Row synchronizer. Reset to all-released (rows are active-low) so a
    // freshly reset scanner never sees phantom presses.
    // ------------------------------------------------------------------
    logic [ROWS-1:0] row_meta;
    logic [ROWS-1:0] row_sync;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column scan
    // ------------------------------------------------------------------
    logic        tick;
    logic [1:0]  col_idx;
    logic [15:0] raw;
    logic        sweep_done;

    scan_pulse #(
        .DIV (SCAN_DIV)
    ) u_scan_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Sample the driven column's rows, then advance to the next column.
    // sweep_done marks the cycle after the last column has been captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_idx    <= '0;
            col        <= COL_RESET;
            raw        <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= tick && (col_idx == 2'd3);
            if (tick) begin
                raw[{col_idx, 2'b00} +: 4] <= ~row_sync;
                col_idx                    <= col_idx + 2'd1;
                col                        <= ~(4'b0001 << (col_idx + 2'd1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot debounce
    // ------------------------------------------------------------------
    logic [15:0]   candidate;
    logic [SW-1:0] stable_cnt;
    logic          raw_match;
    logic          accept;
    logic [15:0]   new_keys;
    logic          press_pulse;
    logic          repeat_pulse;

    assign raw_match   = (raw == candidate);
    assign accept      = sweep_done && raw_match && (stable_cnt >= CNT_MAX) &&
                         (candidate != keys_stable);
    assign new_keys    = candidate & ~keys_stable;
    assign press_pulse = accept && (new_keys != 16'd0);

    // Track how many consecutive sweeps have repeated the candidate snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            candidate  <= '0;
            stable_cnt <= '0;
        end else if (sweep_done) begin
            if (raw_match) begin
                if (stable_cnt < CNT_MAX) stable_cnt <= stable_cnt + SW'(1);
            end else begin
                candidate  <= raw;
                stable_cnt <= '0;
            end
        end
    end

    // Publish accepted snapshots and key events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keys_stable <= '0;
            key_down    <= 1'b0;
            key_code    <= '0;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= press_pulse || repeat_pulse;
            if (accept) begin
                keys_stable <= candidate;
                key_down    <= |candidate;
                if (new_keys != 16'd0) key_code <= lowest_set(new_keys);
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat of the reported key while it stays held.
    // ------------------------------------------------------------------
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic [RW-1:0] rpt_target;
    logic          held;

    // The key counts as held by the snapshot that is current after this sweep.
    assign held         = accept ? candidate[key_code] : keys_stable[key_code];
    assign rpt_target   = rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
    assign repeat_pulse = sweep_done && !press_pulse && held &&
                          (rpt_cnt + RW'(1) == rpt_target);

    // Count sweeps since the last report of the held key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (sweep_done) begin
            if (press_pulse || !held) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (rpt_cnt + RW'(1) == rpt_target) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + RW'(1);
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the
// column pins; a sweep-level reference model predicts the debounced map and
// the key events, checked every cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int RPT_DLY  = 5;
  localparam int RPT_RATE = 2;
  localparam int SWEEP    = 4 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys_stable;

  logic [15:0] pressed;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_DELAY   (RPT_DLY),
    .REPEAT_RATE    (RPT_RATE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .keys_stable (keys_stable)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[c*4 + r]) row[r] = 1'b0;
        end
      end
    end
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // reference model (sweep granularity)
  logic [15:0] hist[$];
  logic [15:0] m_stable, nxt_stable;
  logic [3:0]  m_code, nxt_code;
  bit          nxt_pulse;
  int          m_rpt;
  bit          m_first;

  task automatic model_reset();
    hist.delete();
    m_stable   = '0;
    nxt_stable = '0;
    m_code     = '0;
    nxt_code   = '0;
    nxt_pulse  = 0;
    m_rpt      = 0;
    m_first    = 1;
  endtask

  // A snapshot is accepted once DEB+1 consecutive sweeps read it and it
  // differs from the current map; only the lowest newly pressed key is reported.
  task automatic model_sweep(input logic [15:0] pat);
    bit          acc;
    bit          all_same;
    logic [15:0] newp;
    bit          press;
    bit          held;
    hist.push_back(pat);
    if (hist.size() > DEB + 1) void'(hist.pop_front());
    all_same = (hist.size() == DEB + 1);
    foreach (hist[i]) if (hist[i] != pat) all_same = 0;
    acc        = all_same && (pat != m_stable);
    newp       = pat & ~m_stable;
    press      = acc && (newp != 16'd0);
    nxt_stable = acc ? pat : m_stable;
    nxt_code   = m_code;
    nxt_pulse  = 0;
    if (press) begin
      for (int i = 0; i < 16; i++) begin
        if (newp[i]) begin
          nxt_code = 4'(i);
          break;
        end
      end
      nxt_pulse = 1;
    end
    held = acc ? pat[m_code] : m_stable[m_code];
`ifdef KEYPAD_REPEAT_EN
    if (press || !held) begin
      m_rpt   = 0;
      m_first = 1;
    end else begin
      m_rpt++;
      if (m_rpt == (m_first ? RPT_DLY : RPT_RATE)) begin
        nxt_pulse = 1;
        m_rpt     = 0;
        m_first   = 0;
      end
    end
`else
    if (press || !held) m_rpt = 0;
`endif
  endtask

  // Called at the falling edge just after a sweep boundary; applies the
  // pattern for the coming sweep and checks every cycle of it.
  task automatic run_sweep(input logic [15:0] pat);
    logic [3:0] exp_col;
    bit         exp_valid;
    pressed = pat;
    for (int p = 0; p < SWEEP; p++) begin
      if (p > 0) @(negedge clk);
      exp_valid = 0;
      if (p == 1) begin
        m_stable  = nxt_stable;
        m_code    = nxt_code;
        exp_valid = nxt_pulse;
        if (nxt_pulse) exp_q.push_back(nxt_code);
        nxt_pulse = 0;
      end
      exp_col = 4'hF;
      exp_col[p / SCAN_DIV] = 1'b0;
      check_eq("col", 16'(col), 16'(exp_col));
      check_eq("key_valid", 16'(key_valid), 16'(exp_valid));
      check_eq("keys_stable", keys_stable, m_stable);
      check_eq("key_down", 16'(key_down), 16'(|m_stable));
      check_eq("key_code", 16'(key_code), 16'(m_code));
      if (key_valid) begin
        if (exp_q.size() == 0) check_eq("unexpected_event", 16'(key_code), 16'hFFFF);
        else check_eq("event_code", 16'(key_code), 16'(exp_q.pop_front()));
      end
    end
    @(negedge clk);
    model_sweep(pat);
  endtask

  task automatic hold(input logic [15:0] pat, input int sweeps);
    for (int i = 0; i < sweeps; i++) run_sweep(pat);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_eq("rst_col", 16'(col), 16'(4'b1110));
    check_eq("rst_keys_stable", keys_stable, 16'h0000);
    check_eq("rst_key_valid", 16'(key_valid), 16'h0000);
    check_eq("rst_key_down", 16'(key_down), 16'h0000);
    check_eq("rst_key_code", 16'(key_code), 16'h0000);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  function automatic logic [15:0] rand_pattern();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'h0000;
      1:       v = 16'h0001 << $urandom_range(0, 15);
      2:       v = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      default: v = 16'($urandom());
    endcase
    return v;
  endfunction

  initial begin
    rst_n   = 1'b0;
    pressed = '0;
    model_reset();

    // reset and idle column walk
    do_reset(3);
    hold(16'h0000, 2);

    // single press of key 10 and release
    hold(16'h0400, 6);
    hold(16'h0000, 5);

    // bouncing key 5, then held
    for (int i = 0; i < 6; i++) run_sweep((i % 2 == 0) ? 16'h0020 : 16'h0000);
    hold(16'h0020, 5);
    hold(16'h0000, 5);

    // simultaneous keys 3 and 12
    hold(16'h1008, 6);
    hold(16'h0000, 5);

    // reset in the middle of debouncing key 7
    hold(16'h0080, 2);
    do_reset(1);
    hold(16'h0080, 6);
    hold(16'h0000, 5);

    // long hold (exercises auto-repeat when built in)
    hold(16'h0200, 14);
    hold(16'h0000, 5);

    // randomized segments, including short glitches
    for (int s = 0; s < 120; s++) hold(rand_pattern(), $urandom_range(1, 6));
    hold(16'h0000, 6);

    check_eq("events_drained", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
